// File: rtl/dense_grad_row_10_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dense_grad_row_10_if                                         |
// | Description : Bundle of the sample stream (valid_in/ready_out/dy/x) and     |
// |               the gradient row stream (valid_out/ready_in/q) of the         |
// |               10-lane dense gradient accumulator.                           |
// |   master : the environment side (drives samples, consumes gradients)       |
// |   slave  : the accumulator side                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface dense_grad_row_10_if #(
  parameter int DATA_WIDTH1 = 16,
  parameter int DATA_WIDTH2 = 16
);
  logic                      valid_in;
  logic                      ready_out;
  logic [DATA_WIDTH1-1:0]    dy;
  logic [10*DATA_WIDTH2-1:0] x;
  logic                      valid_out;
  logic                      ready_in;
  logic [10*DATA_WIDTH1-1:0] q;

  modport master (
    output valid_in, dy, x, ready_in,
    input  ready_out, valid_out, q
  );

  modport slave (
    input  valid_in, dy, x, ready_in,
    output ready_out, valid_out, q
  );
endinterface
`default_nettype wire

// File: rtl/dense_grad_row_10.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dense_grad_row_10                                            |
// | Description : Backward-pass gradient row for a 10-input dense neuron.      |
// |               Forms dy*x[i] in signed fixed point (F_LEN fractional bits), |
// |               accumulates BATCH samples per lane and hands the finished    |
// |               10-element gradient row downstream with valid/ready.         |
// | Ports       : clk       - single clock, rising edge                        |
// |               rst_n     - synchronous, active-low reset                    |
// |               bus       - slave side of dense_grad_row_10_if:              |
// |                 valid_in/ready_out/dy/x    : sample input stream           |
// |                 valid_out/ready_in/q       : gradient row output stream    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dense_grad_row_10 #(
  parameter int N_LEN       = 16,
  parameter int F_LEN       = 8,
  parameter int DATA_WIDTH1 = N_LEN,
  parameter int DATA_WIDTH2 = N_LEN,
  parameter int BATCH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dense_grad_row_10_if.slave    bus
);

  localparam int LANES = 10;
  localparam int PW    = DATA_WIDTH1 + DATA_WIDTH2;
  localparam logic [7:0] BATCH_CNT = 8'(BATCH);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [7:0]             cnt;
  logic [7:0]             cnt_next;
  logic                   accept;
  logic                   ready_out;
  logic                   valid_out;

  logic [DATA_WIDTH1-1:0] p_next [LANES];
  logic [DATA_WIDTH1-1:0] p      [LANES];
  logic                   p_valid;
  logic                   p_first;
  logic [DATA_WIDTH1-1:0] acc    [LANES];
  logic [10*DATA_WIDTH1-1:0] q_flat;

  // Full-width signed product per lane; an arithmetic shift by F_LEN followed
  // by truncation to DATA_WIDTH1 floors toward -inf and wraps the upper bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0] prod;
    assign prod      = $signed(bus.dy) * $signed(bus.x[i*DATA_WIDTH2 +: DATA_WIDTH2]);
    assign p_next[i] = DATA_WIDTH1'(prod >>> F_LEN);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and handshake outputs; both handshake outputs decode the
  // registered state only, so neither depends on valid_in or ready_in.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_out  = 1'b0;
    valid_out  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_ACC: begin
        ready_out = 1'b1;
        if (bus.valid_in) begin
          accept   = 1'b1;
          cnt_next = cnt + 8'd1;
          if (cnt + 8'd1 == BATCH_CNT) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last product sits in the pipeline register this cycle and
        // lands in the accumulators on the edge that leaves DRAIN.
        state_next = ST_OUT;
      end
      ST_OUT: begin
        valid_out = 1'b1;
        if (bus.ready_in) begin
          state_next = ST_ACC;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = ST_ACC;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Product pipeline stage and accumulators. The first sample of a batch
  // loads the accumulator instead of adding, so no clear cycle is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        p[i]   <= '0;
        acc[i] <= '0;
      end
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_first <= (cnt == 8'd0);
        for (int i = 0; i < LANES; i++) begin
          p[i] <= p_next[i];
        end
      end
      if (p_valid) begin
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= p_first ? p[i] : acc[i] + p[i];
        end
      end
    end
  end

  always_comb begin
    q_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      q_flat[i*DATA_WIDTH1 +: DATA_WIDTH1] = acc[i];
    end
  end

  assign bus.q         = q_flat;
  assign bus.ready_out = ready_out;
  assign bus.valid_out = valid_out;

endmodule
`default_nettype wire

// File: tb/tb_dense_grad_row_10.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dense_grad_row_10                                         |
// | Description : Self-checking bench for dense_grad_row_10. A BATCH=4 unit   |
// |               carries most scenarios; a BATCH=1 unit covers sign and       |
// |               truncation. Expected rows come from a fixed-point model and  |
// |               are queued when samples are driven, popped on valid_out.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dense_grad_row_10;

  localparam int B = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dense_grad_row_10_if #(.DATA_WIDTH1(16), .DATA_WIDTH2(16)) bus4 ();
  dense_grad_row_10_if #(.DATA_WIDTH1(16), .DATA_WIDTH2(16)) bus1 ();

  dense_grad_row_10 #(.N_LEN(16), .F_LEN(8), .BATCH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  dense_grad_row_10 #(.N_LEN(16), .F_LEN(8), .BATCH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;

  logic [159:0] sb [$];
  logic [15:0]  m_acc [10];
  int           m_cnt = 0;

  // Q8.8 product: full signed product, keep bits [23:8].
  function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] f;
    f = $signed(a) * $signed(b);
    return f[23:8];
  endfunction

  function automatic logic [159:0] rand_x();
    logic [159:0] v;
    for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Presents one sample to the BATCH=4 unit, holds it until accepted and
  // advances the model; valid_in stays high so samples go back to back.
  task automatic drive_sample(input logic [15:0] d, input logic [159:0] xv);
    int k = 0;
    logic [15:0] pv;
    bus4.dy       = d;
    bus4.x        = xv;
    bus4.valid_in = 1'b1;
    while (bus4.ready_out !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    total++;
    if (bus4.ready_out !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: ready_out=%b required 1", bus4.ready_out);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      pv = ref_prod(d, xv[i*16 +: 16]);
      m_acc[i] = (m_cnt == 0) ? pv : m_acc[i] + pv;
    end
    m_cnt++;
    if (m_cnt == B) begin
      logic [159:0] e;
      for (int i = 0; i < 10; i++) e[i*16 +: 16] = m_acc[i];
      sb.push_back(e);
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    bus4.valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus4.valid_in = 1'b0;
    bus1.valid_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    bus4.ready_in = 1'b0;
    bus1.ready_in = 1'b0;
    do_reset();
    total++;
    if (bus4.q !== 160'd0) begin bad++; $display("FAIL reset_q: got %h required 0", bus4.q); end
    total++;
    if (bus4.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b required 0", bus4.valid_out); end
    total++;
    if (bus4.ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_out: got %b required 1", bus4.ready_out); end
    total++;
    if (bus1.q !== 160'd0 || bus1.valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_b1: q=%h valid_out=%b required 0/0", bus1.q, bus1.valid_out);
    end
  endtask

  task automatic test_basic();
    logic [159:0] xv, e_const, e;
    bus4.ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      xv[i*16 +: 16]      = 16'((i + 1) * 256);
      e_const[i*16 +: 16] = 16'(4 * (i + 1) * 256);
    end
    for (int s = 0; s < 4; s++) drive_sample(16'h0100, xv);
    bus4.valid_in = 1'b0;
    total++;
    if (bus4.ready_out !== 1'b0 || bus4.valid_out !== 1'b0) begin
      bad++; $display("FAIL basic_drain: ready_out=%b valid_out=%b required 0/0", bus4.ready_out, bus4.valid_out);
    end
    @(posedge clk); #1;
    total++;
    if (bus4.valid_out !== 1'b1 || bus4.ready_out !== 1'b0) begin
      bad++; $display("FAIL basic_out: valid_out=%b ready_out=%b required 1/0", bus4.valid_out, bus4.ready_out);
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL basic_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (bus4.q !== e) begin bad++; $display("FAIL basic_q: got %h required %h", bus4.q, e); end
    end
    total++;
    if (bus4.q !== e_const) begin bad++; $display("FAIL basic_q_const: got %h required %h", bus4.q, e_const); end
    @(posedge clk); #1;
    total++;
    if (bus4.valid_out !== 1'b0 || bus4.ready_out !== 1'b1) begin
      bad++; $display("FAIL basic_after: valid_out=%b ready_out=%b required 0/1", bus4.valid_out, bus4.ready_out);
    end
  endtask

  task automatic test_sign();
    bus1.ready_in     = 1'b1;
    bus1.dy           = 16'hFF80;
    bus1.x            = 160'd0;
    bus1.x[15:0]      = 16'h0180;
    bus1.x[31:16]     = 16'h0001;
    bus1.valid_in     = 1'b1;
    @(posedge clk); #1;
    bus1.valid_in = 1'b0;
    total++;
    if (bus1.valid_out !== 1'b0 || bus1.ready_out !== 1'b0) begin
      bad++; $display("FAIL sign_drain: valid_out=%b ready_out=%b required 0/0", bus1.valid_out, bus1.ready_out);
    end
    @(posedge clk); #1;
    total++;
    if (bus1.valid_out !== 1'b1) begin bad++; $display("FAIL sign_valid: got %b required 1", bus1.valid_out); end
    total++;
    if (bus1.q[15:0] !== 16'hFF40) begin bad++; $display("FAIL sign_q0: got %h required ff40", bus1.q[15:0]); end
    total++;
    if (bus1.q[31:16] !== 16'hFFFF) begin bad++; $display("FAIL sign_q1: got %h required ffff", bus1.q[31:16]); end
    total++;
    if (bus1.q[159:32] !== 128'd0) begin bad++; $display("FAIL sign_qrest: got %h required 0", bus1.q[159:32]); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [159:0] xv, e;
    int k = 0;
    bus4.ready_in = 1'b1;
    xv = 160'd0;
    xv[15:0]  = 16'h0200;
    xv[31:16] = 16'h0080;
    for (int s = 0; s < 4; s++) drive_sample(16'h7F00, xv);
    bus4.valid_in = 1'b0;
    while (bus4.valid_out !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    total++;
    if (bus4.valid_out !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL wrap_timeout: valid_out=%b required 1", bus4.valid_out);
    end else begin
      e = sb.pop_front();
      if (bus4.q !== e) begin bad++; $display("FAIL wrap_q: got %h required %h", bus4.q, e); end
    end
    // 127.0*2.0 wraps to -2.0 (0xFE00) per sample; four of those give 0xF800.
    total++;
    if (bus4.q[15:0] !== 16'hF800) begin bad++; $display("FAIL wrap_q0: got %h required f800", bus4.q[15:0]); end
    total++;
    if (bus4.q[31:16] !== 16'hFE00) begin bad++; $display("FAIL wrap_q1: got %h required fe00", bus4.q[31:16]); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [159:0] hold, e;
    int k = 0;
    bus4.ready_in = 1'b0;
    drive_sample(16'($urandom), rand_x());
    drive_sample(16'($urandom), rand_x());
    idle(3);
    total++;
    if (bus4.ready_out !== 1'b1 || bus4.valid_out !== 1'b0) begin
      bad++; $display("FAIL gap_hold: ready_out=%b valid_out=%b required 1/0", bus4.ready_out, bus4.valid_out);
    end
    drive_sample(16'($urandom), rand_x());
    drive_sample(16'($urandom), rand_x());
    bus4.valid_in = 1'b0;
    while (bus4.valid_out !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    hold = bus4.q;
    total++;
    if (bus4.valid_out !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL bp_timeout: valid_out=%b required 1", bus4.valid_out);
    end else begin
      e = sb.pop_front();
      if (bus4.q !== e) begin bad++; $display("FAIL bp_q: got %h required %h", bus4.q, e); end
    end
    // Offer junk samples while stalled in OUT; none may be taken.
    for (int c = 0; c < 5; c++) begin
      bus4.valid_in = 1'b1;
      bus4.dy       = 16'($urandom);
      bus4.x        = rand_x();
      @(posedge clk); #1;
      total++;
      if (bus4.valid_out !== 1'b1 || bus4.ready_out !== 1'b0 || bus4.q !== hold) begin
        bad++;
        $display("FAIL bp_stall%0d: valid_out=%b ready_out=%b q=%h required 1/0 q=%h",
                 c, bus4.valid_out, bus4.ready_out, bus4.q, hold);
      end
    end
    bus4.valid_in = 1'b0;
    bus4.ready_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus4.valid_out !== 1'b0 || bus4.ready_out !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid_out=%b ready_out=%b required 0/1", bus4.valid_out, bus4.ready_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] e;
    bus4.ready_in = 1'b1;
    for (int b = 0; b < 2; b++) begin
      int k = 0;
      for (int s = 0; s < 4; s++) drive_sample(16'($urandom), rand_x());
      bus4.valid_in = 1'b0;
      while (bus4.valid_out !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
      total++;
      if (bus4.valid_out !== 1'b1 || sb.size() == 0) begin
        bad++; $display("FAIL b2b_timeout%0d: valid_out=%b required 1", b, bus4.valid_out);
      end else begin
        e = sb.pop_front();
        if (bus4.q !== e) begin bad++; $display("FAIL b2b_q%0d: got %h required %h", b, bus4.q, e); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [159:0] e;
    int k = 0;
    bus4.ready_in = 1'b1;
    drive_sample(16'($urandom), rand_x());
    drive_sample(16'($urandom), rand_x());
    do_reset();
    total++;
    if (bus4.q !== 160'd0 || bus4.valid_out !== 1'b0 || bus4.ready_out !== 1'b1) begin
      bad++; $display("FAIL rstmid_state: q=%h valid_out=%b ready_out=%b required 0/0/1",
                      bus4.q, bus4.valid_out, bus4.ready_out);
    end
    for (int s = 0; s < 4; s++) drive_sample(16'($urandom), rand_x());
    bus4.valid_in = 1'b0;
    while (bus4.valid_out !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    total++;
    if (bus4.valid_out !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL rstmid_timeout: valid_out=%b required 1", bus4.valid_out);
    end else begin
      e = sb.pop_front();
      if (bus4.q !== e) begin bad++; $display("FAIL rstmid_q: got %h required %h", bus4.q, e); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus4.valid_in = 1'b0;
    bus4.ready_in = 1'b0;
    bus4.dy       = '0;
    bus4.x        = '0;
    bus1.valid_in = 1'b0;
    bus1.ready_in = 1'b0;
    bus1.dy       = '0;
    bus1.x        = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_sign();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: %0d rows never produced", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
